// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem read FSM and a
// 2-entry {pc,inst} queue presented to decode over valid/ready.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_DROP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] head_pc_q, head_pc_d, head_inst_q, head_inst_d;
   logic [31:0] tail_pc_q, tail_pc_d, tail_inst_q, tail_inst_d;
   logic        issue_s, push_s, pop_s;
   logic        unused_s;

   // A fetch is only issued with nothing outstanding (FETCH), so count_q alone
   // tells whether a slot can be reserved for the response.
   assign issue_s   = (state_q == S_FETCH) && (count_q != 2'd2) && !redirect_valid;
   assign push_s    = (state_q == S_WAIT) && imem_valid;
   assign pop_s     = (count_q != 2'd0) && out_ready;
   assign unused_s  = ^redirect_pc[1:0];

   assign imem_req  = issue_s && rst_n;
   assign imem_addr = pc_q;
   assign out_valid = (count_q != 2'd0);
   assign out_inst  = head_inst_q;
   assign out_pc    = head_pc_q;

   // Next-state logic; a redirect waits out any request still in flight in DROP.
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         if ((state_q != S_FETCH) && !imem_valid) begin
            state_d = S_DROP;
         end else begin
            state_d = S_FETCH;
         end
      end else begin
         case (state_q)
            S_FETCH: begin
               if (issue_s) state_d = S_WAIT;
               else         state_d = S_FETCH;
            end
            S_WAIT: begin
               if (imem_valid) state_d = S_FETCH;
               else            state_d = S_WAIT;
            end
            S_DROP: begin
               if (imem_valid) state_d = S_FETCH;
               else            state_d = S_DROP;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   // PC: redirect target (word aligned) or advance past the word just pushed.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = {redirect_pc[31:2], 2'b00};
      end else if (push_s) begin
         pc_d = pc_q + 32'd4;
      end else begin
         pc_d = pc_q;
      end
   end

   // Queue update; the head registers idle at {0,NOP} so outputs need no muxing.
   always_comb begin
      count_d     = count_q;
      head_pc_d   = head_pc_q;
      head_inst_d = head_inst_q;
      tail_pc_d   = tail_pc_q;
      tail_inst_d = tail_inst_q;
      if (redirect_valid) begin
         count_d     = 2'd0;
         head_pc_d   = 32'd0;
         head_inst_d = NOP_INST;
         tail_pc_d   = 32'd0;
         tail_inst_d = NOP_INST;
      end else begin
         case ({push_s, pop_s})
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_pc_d   = pc_q;
                  head_inst_d = imem_rdata;
               end else begin
                  head_pc_d   = tail_pc_q;
                  head_inst_d = tail_inst_q;
                  tail_pc_d   = pc_q;
                  tail_inst_d = imem_rdata;
               end
            end
            2'b01: begin
               if (count_q == 2'd1) begin
                  count_d     = 2'd0;
                  head_pc_d   = 32'd0;
                  head_inst_d = NOP_INST;
               end else begin
                  count_d     = 2'd1;
                  head_pc_d   = tail_pc_q;
                  head_inst_d = tail_inst_q;
               end
            end
            2'b10: begin
               if (count_q == 2'd0) begin
                  count_d     = 2'd1;
                  head_pc_d   = pc_q;
                  head_inst_d = imem_rdata;
               end else begin
                  count_d     = 2'd2;
                  tail_pc_d   = pc_q;
                  tail_inst_d = imem_rdata;
               end
            end
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         count_q     <= 2'd0;
         head_pc_q   <= 32'd0;
         head_inst_q <= NOP_INST;
         tail_pc_q   <= 32'd0;
         tail_inst_q <= NOP_INST;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         count_q     <= count_d;
         head_pc_q   <= head_pc_d;
         head_inst_q <= head_inst_d;
         tail_pc_q   <= tail_pc_d;
         tail_inst_q <= tail_inst_d;
      end
   end

endmodule
